// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 32x8 memory between NUM_REQ requesters.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for lowest-index priority.
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 5,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DW-1:0]         mem_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xact_t;

  state_t             state_q, state_d;
  xact_t              xact_q, xact_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_data_q, mem_data_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_read_q, mem_read_d;
  logic [IW-1:0]      win;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IW-1:0] i
  );
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Descending scan: the last hit, i.e. the lowest index, wins.
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = IW'(k);
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] rr_nxt;

  // Descending offset scan: the smallest offset from rr_q wins.
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) win = IW'(j);
    end
  end

  assign rr_nxt = (xact_q.id == IW'(NUM_REQ - 1)) ?
                  '0 : xact_q.id + 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    xact_d      = xact_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          xact_d.id    = win;
          xact_d.we    = req_we[win];
          xact_d.addr  = req_addr[int'(win)*AW +: AW];
          xact_d.wdata = req_wdata[int'(win)*DW +: DW];
          gnt_d        = onehot(win);
          mem_addr_d   = xact_d.addr;
          mem_data_d   = xact_d.wdata;
          mem_write_d  = xact_d.we;
          mem_read_d   = !xact_d.we;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_d = rr_nxt;
`endif
        if (xact_q.we) begin
          rsp_valid_d = onehot(xact_q.id);
          state_d     = RESP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rsp_rdata_d = mem_data_out;
        rsp_valid_d = onehot(xact_q.id);
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xact_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      xact_q      <= xact_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 32x8 memory (5-bit address, 8-bit data) between NUM_REQ requesters.
- Round-robin arbitration; a one-cycle registered read/write strobe per access.
- Sits between requester agents (test programs, DMA-style masters) and the memory's interface signals.
- Serialises all accesses; returns read data and completion to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 5, address width.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester access request, level.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW].
- gnt  out  NUM_REQ  one-hot, high during the ACCESS cycle of the winner.
- rsp_valid  out  NUM_REQ  one-hot completion pulse, 1 cycle.
- rsp_rdata  out  DW  read data, valid with rsp_valid for reads.
- mem_addr  out  AW  memory address.
- mem_data_in  out  DW  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_data_out  in  DW  memory read data, valid the cycle after mem_read.

Behaviour:
- All outputs are registered. Reset values: gnt=0, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_data_in=0, mem_write=0, mem_read=0. State=IDLE, rr_ptr=0.
- FSM states: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE: if any req bit is high, select the winner by round-robin, searching from rr_ptr upward with wrap at NUM_REQ-1 to 0. Latch the winner's id, we, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle): gnt[id]=1; mem_addr and mem_data_in carry the latched values. mem_write=we, mem_read=!we. rr_ptr <= id+1, mod NUM_REQ. Next state is RESP for a write, RD_WAIT for a read.
- RD_WAIT (1 cycle): strobes low; mem_data_out is captured into rsp_rdata at the end of the cycle. Next state is RESP.
- RESP (1 cycle): rsp_valid[id]=1, then return to IDLE. rsp_rdata holds its value until the next read completes; writes do not alter it.
- Latency from req sampled in IDLE at cycle T:
  - write: gnt at T+1, rsp_valid at T+2.
  - read: gnt at T+1, rsp_valid and data at T+3.
  - Back-to-back throughput: writes every 3 cycles, reads every 4 cycles.
- Requester rules: hold req, req_we, req_addr and req_wdata stable until rsp_valid; deassert req in the cycle after rsp_valid. Changes to req fields after the IDLE sample have no effect on the access in flight.
- Simultaneous requests: exactly one grant per transaction. A waiting requester is served within NUM_REQ transactions.
- req dropped during an access: the access completes and rsp_valid is still issued.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight access is abandoned; a write may be partial only if reset lands in the ACCESS cycle.
- mem_addr and mem_data_in hold their last values outside ACCESS. Strobes are high only in ACCESS, and never both at once.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed, and starvation of high indices is permitted.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then requester 0 writes addr 5'h03 data 8'hA5 → gnt[0] at T+1 with mem_write=1, mem_addr=03, mem_data_in=A5; rsp_valid[0] at T+2.
- Requester 1 reads 5'h03 after that write → mem_read at T+1, rsp_valid[1] at T+3 with rsp_rdata=8'hA5.
- All four requesters hold writes (addr=i, data=i) simultaneously from reset → grant order 0,1,2,3. Read-back of addr 0..4 returns 00,01,02,03 and location 4 unchanged.
- Requesters 0 and 2 request continuously → grants alternate 0,2,0,2. With MEM_ARB_FIXED_PRIO_EN → only 0 is granted.
- Clear sweep: requester 3 writes 8'h00 to addr 0..31 → memory all zero; every rsp_valid[3] arrives exactly 2 cycles after its IDLE sample.
- rst_n pulsed low during RD_WAIT → all outputs 0 immediately; no rsp_valid is issued. The first grant after reset goes to requester 0.
